exec_stage_mc: RTL and testbench
================================

Name: exec_stage_mc

Overview:
Parametrised execute stage for the five-stage pipeline. It selects operands through the IN-port and forwarding muxes and executes single-cycle ALU ops. It also runs a multi-cycle iterative unsigned multiply that stalls upstream while busy. The block owns the condition-code register and registers its results into the EX/MEM boundary.

Parameters:
DATA_W, 16, datapath width (op1/op2/result/address)
OP_W, 5, ALU opcode width
FWD_EN, 1, 1 = forwarding muxes present; 0 = forward selects ignored, raw operands used

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-low
in_valid  in  1  instruction present at stage input
flush  in  1  kill current/in-flight instruction (branch taken)
op1  in  DATA_W  register-file source 1
op2  in  DATA_W  register-file source 2
inport  in  DATA_W  external IN port
immediate  in  DATA_W  sign-extended immediate
shamt  in  DATA_W  shift amount (low log2(DATA_W) bits used)
alu_op  in  OP_W  opcode (encodings in package)
alu_src  in  2  op2 select: 0 reg/fwd, 1 immediate, 2 shamt, 3 reserved (=reg/fwd)
in_sel  in  1  op1 = inport when 1
branch  in  1  mem_addr source: 1 op1, 0 op2
ex_mem_fwd  in  DATA_W  forward value from EX/MEM
mem_wb_fwd  in  DATA_W  forward value from MEM/WB
fwd1_sel  in  2  op1 forward select: 0 none, 1 EX/MEM, 2 MEM/WB, 3 = none
fwd2_sel  in  2  op2 forward select, same encoding
stall  out  1  upstream must hold inputs
out_valid  out  1  registered result valid
result  out  DATA_W  registered result (MUL: low half)
result_hi  out  DATA_W  MUL high half, else 0
mem_addr  out  DATA_W  registered memory address
ccr  out  3  {C,N,Z} flags, registered

Behaviour:
- Reset (rst=0 at clk edge): out_valid, result, result_hi, mem_addr, ccr = 0. FSM -> IDLE. stall = 0. Reset overrides everything, including a mid-MUL operation.
- Operand path: a = in_sel ? inport : op1, then the fwd1 mux. b = fwd2 mux of op2, then the alu_src mux. mem_addr uses the raw op1/op2 (pre-forward).
- Single-cycle ops (ADD, SUB, AND, OR, NOT, INC, DEC, SHL, SHR, MOV, SETC, CLRC, NOP):
  - Accepted when in_valid & IDLE & !flush.
  - Outputs are registered at the next edge; out_valid = 1 for exactly one cycle. Latency 1.
- Flags:
  - Z and N are updated from the DATA_W-bit result by arithmetic/logic ops only.
  - C: carry-out for ADD/INC. Borrow for SUB/DEC (C = a < b unsigned). Last bit shifted out for SHL/SHR; shift by 0 leaves C unchanged. SETC=1, CLRC=0.
  - MOV and NOP leave ccr unchanged.
- MUL FSM: IDLE -> BUSY -> DONE -> IDLE.
  - IDLE->BUSY on an accepted MUL: a and b are latched and a counter is loaded with DATA_W. stall = 1 combinationally in the accept cycle and throughout BUSY.
  - BUSY: one shift-add step per cycle. Counter decrements; at 1 -> DONE.
  - DONE: result/result_hi = 2*DATA_W product, out_valid = 1 for one cycle. stall = 0. Z set iff full product = 0, N = product MSB, C = (result_hi != 0). Return to IDLE.
  - Total latency: DATA_W+1 cycles from accept to out_valid.
- Flush:
  - In IDLE, the current instruction is discarded: out_valid = 0 next cycle and ccr unchanged.
  - In BUSY, the FSM aborts to IDLE next cycle with stall dropped; no out_valid and ccr unchanged.
- A flush in DONE is too late: the result still issues.
- in_valid = 0: out_valid = 0, result/ccr held.
- Unknown opcode: treated as NOP (out_valid = 1, result = 0, ccr held).

Decomposition:
- Package exec_pkg:
  - alu_op encodings (NOP=0, ADD, SUB, AND, OR, NOT, INC, DEC, SHL, SHR, MOV, SETC, CLRC, MUL).
  - fwd/alu_src select constants.
  - CCR bit indices Z=0, N=1, C=2.
- Sub-module: mul_iter (iterative shift-add multiplier with start/busy/done, parametrised DATA_W). The ALU stays inline.

Test Plan:
- Reset: drive rst=0 for 2 cycles during a MUL -> all outputs 0, stall=0, FSM IDLE.
- ADD with in_sel=1: inport=0x7FFF, op2=0x0001, alu_src=0 -> next cycle result=0x8000, ccr={C0,N1,Z0}, out_valid=1 for 1 cycle.
- Forwarding plus carry:
  - SUB: op1=5, fwd2_sel=1, ex_mem_fwd=5 -> result=0, Z=1, C=0.
  - Then SUB with b=6 -> result=0xFFFF, N=1, C=1.
- MUL: a=0x1234, b=0x0100 (DATA_W=16):
  - stall high 16 cycles.
  - out_valid on cycle 17 with result=0x3400, result_hi=0x0012, C=1.
- Flush in BUSY: assert flush at cycle 5 of a MUL -> stall low next cycle, no out_valid, ccr unchanged.
- Shift edge: SHL by shamt=0 on 0x8001 -> result=0x8001, C unchanged. SHL by 1 -> result=0x0002, C=1.

Source files
------------

// File: rtl/exec_pkg.sv
// ---------------------------------------------------------------------------
// exec_pkg
// Shared encodings for the execute stage: ALU opcodes, operand-select codes,
// condition-code bit positions and the multiplier sequencer states.
// ---------------------------------------------------------------------------
package exec_pkg;

  // ALU opcodes. Any code not listed here executes as NOP.
  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_ADD  = 5'd1,
    OP_SUB  = 5'd2,
    OP_AND  = 5'd3,
    OP_OR   = 5'd4,
    OP_NOT  = 5'd5,
    OP_INC  = 5'd6,
    OP_DEC  = 5'd7,
    OP_SHL  = 5'd8,
    OP_SHR  = 5'd9,
    OP_MOV  = 5'd10,
    OP_SETC = 5'd11,
    OP_CLRC = 5'd12,
    OP_MUL  = 5'd13
  } alu_op_e;

  // Forwarding mux selects (code 3 behaves as FWD_NONE).
  localparam logic [1:0] FWD_NONE   = 2'd0;
  localparam logic [1:0] FWD_EX_MEM = 2'd1;
  localparam logic [1:0] FWD_MEM_WB = 2'd2;

  // Second-operand source selects (code 3 behaves as SRC_REG).
  localparam logic [1:0] SRC_REG   = 2'd0;
  localparam logic [1:0] SRC_IMM   = 2'd1;
  localparam logic [1:0] SRC_SHAMT = 2'd2;

  // Condition-code register bit positions: ccr = {C, N, Z}.
  localparam int CCR_Z = 0;
  localparam int CCR_N = 1;
  localparam int CCR_C = 2;

  // Multiplier sequencer states.
  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/exec_stage_mc_mul.sv
// ---------------------------------------------------------------------------
// mul_iter
// Iterative unsigned shift-add multiplier, one partial-product step per clock.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   start             load operands and begin (honoured in IDLE only)
//   abort             drop an in-progress multiply, return to IDLE
//   mcand_in/mplier_in operands (DATA_W bits each)
//   busy              stepping in progress
//   done              one-cycle completion state
//   last              current BUSY cycle performs the final step
//   step_product      accumulator value after this cycle's step; equals the
//                     full 2*DATA_W product while 'last' is high
// ---------------------------------------------------------------------------
module mul_iter
  import exec_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_W-1:0]     mcand_in,
  input  logic [DATA_W-1:0]     mplier_in,
  output logic                  busy,
  output logic                  done,
  output logic                  last,
  output logic [2*DATA_W-1:0]   step_product
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  mul_state_e        state;
  mul_state_e        state_next;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] acc_hi;
  logic [DATA_W-1:0] acc_lo;
  logic [DATA_W:0]   sum;

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= MUL_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Sequencer next-state logic; abort wins over the final-step transition.
  always_comb begin
    state_next = state;
    case (state)
      MUL_IDLE: begin
        if (start) begin
          state_next = MUL_BUSY;
        end else begin
          state_next = MUL_IDLE;
        end
      end
      MUL_BUSY: begin
        if (abort) begin
          state_next = MUL_IDLE;
        end else if (count == CNT_W'(1)) begin
          state_next = MUL_DONE;
        end else begin
          state_next = MUL_BUSY;
        end
      end
      MUL_DONE: state_next = MUL_IDLE;
      default:  state_next = MUL_IDLE;
    endcase
  end

  // Sequencer status outputs.
  always_comb begin
    busy = (state == MUL_BUSY);
    done = (state == MUL_DONE);
    last = (state == MUL_BUSY) && (count == CNT_W'(1));
  end

  // One shift-add step: the multiplier occupies the low half and retires one
  // bit per step while the partial sum grows into the high half.
  always_comb begin
    if (acc_lo[0]) begin
      sum = {1'b0, acc_hi} + {1'b0, mcand};
    end else begin
      sum = {1'b0, acc_hi};
    end
    step_product = {sum, acc_lo[DATA_W-1:1]};
  end

  // Operand latch, accumulator and step counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      count  <= '0;
    end else if ((state == MUL_IDLE) && start) begin
      mcand  <= mcand_in;
      acc_hi <= '0;
      acc_lo <= mplier_in;
      count  <= CNT_W'(DATA_W);
    end else if (state == MUL_BUSY) begin
      {acc_hi, acc_lo} <= step_product;
      count            <= count - CNT_W'(1);
    end else begin
      mcand  <= mcand;
      acc_hi <= acc_hi;
      acc_lo <= acc_lo;
      count  <= count;
    end
  end

endmodule

// File: rtl/exec_stage_mc.sv
// ---------------------------------------------------------------------------
// exec_stage_mc
// Execute stage: operand selection (IN port, forwarding, immediate/shamt),
// single-cycle ALU, iterative multiply with upstream stall, condition-code
// register and the EX/MEM output registers.
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   in_valid, flush           instruction present / kill (branch taken)
//   op1, op2                  register-file operands
//   inport, immediate, shamt  alternative operand sources
//   alu_op, alu_src, in_sel   opcode and operand selects
//   branch                    mem_addr source (1: op1, 0: op2)
//   ex_mem_fwd, mem_wb_fwd    forwarded values
//   fwd1_sel, fwd2_sel        forwarding selects
//   stall                     upstream must hold (combinational)
//   out_valid, result, result_hi, mem_addr, ccr   registered EX/MEM outputs
// ---------------------------------------------------------------------------
module exec_stage_mc
  import exec_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 5,
  parameter int FWD_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              flush,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [DATA_W-1:0] inport,
  input  logic [DATA_W-1:0] immediate,
  input  logic [DATA_W-1:0] shamt,
  input  logic [OP_W-1:0]   alu_op,
  input  logic [1:0]        alu_src,
  input  logic              in_sel,
  input  logic              branch,
  input  logic [DATA_W-1:0] ex_mem_fwd,
  input  logic [DATA_W-1:0] mem_wb_fwd,
  input  logic [1:0]        fwd1_sel,
  input  logic [1:0]        fwd2_sel,
  output logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] result_hi,
  output logic [DATA_W-1:0] mem_addr,
  output logic [2:0]        ccr
);

  localparam int SH_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W:0]   ONEW = {{DATA_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0]   a_in;
  logic [DATA_W-1:0]   a;
  logic [DATA_W-1:0]   b_reg;
  logic [DATA_W-1:0]   b;
  logic [SH_W-1:0]     sh;
  logic [DATA_W:0]     wide;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic                upd_zn;
  logic                upd_c;
  logic [2:0]          ccr_next;
  logic                is_mul;
  logic                accept;
  logic                mul_start;
  logic                mul_finish;
  logic                mul_busy;
  logic                mul_done;
  logic                mul_last;
  logic [2*DATA_W-1:0] mul_product;

  // Operand selection: IN port then forwarding for a; forwarding then source mux for b.
  always_comb begin
    a_in  = in_sel ? inport : op1;
    a     = a_in;
    b_reg = op2;
    if (FWD_EN != 0) begin
      case (fwd1_sel)
        FWD_NONE:   a = a_in;
        FWD_EX_MEM: a = ex_mem_fwd;
        FWD_MEM_WB: a = mem_wb_fwd;
        default:    a = a_in;
      endcase
      case (fwd2_sel)
        FWD_NONE:   b_reg = op2;
        FWD_EX_MEM: b_reg = ex_mem_fwd;
        FWD_MEM_WB: b_reg = mem_wb_fwd;
        default:    b_reg = op2;
      endcase
    end else begin
      a     = a_in;
      b_reg = op2;
    end
    case (alu_src)
      SRC_REG:   b = b_reg;
      SRC_IMM:   b = immediate;
      SRC_SHAMT: b = shamt;
      default:   b = b_reg;
    endcase
    sh = b[SH_W-1:0];
  end

  // Single-cycle ALU. Shifts go through a DATA_W+1 wide copy so the bit
  // shifted out lands in the extra position and becomes the carry.
  // MOV passes operand a so an IN-port read can be moved through unchanged.
  always_comb begin
    alu_res = '0;
    alu_c   = ccr[CCR_C];
    upd_zn  = 1'b0;
    upd_c   = 1'b0;
    wide    = '0;
    case (alu_op)
      OP_W'(OP_ADD): begin
        wide    = {1'b0, a} + {1'b0, b};
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
        upd_zn  = 1'b1;
        upd_c   = 1'b1;
      end
      OP_W'(OP_SUB): begin
        alu_res = a - b;
        alu_c   = (a < b);
        upd_zn  = 1'b1;
        upd_c   = 1'b1;
      end
      OP_W'(OP_AND): begin
        alu_res = a & b;
        upd_zn  = 1'b1;
      end
      OP_W'(OP_OR): begin
        alu_res = a | b;
        upd_zn  = 1'b1;
      end
      OP_W'(OP_NOT): begin
        alu_res = ~a;
        upd_zn  = 1'b1;
      end
      OP_W'(OP_INC): begin
        wide    = {1'b0, a} + ONEW;
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
        upd_zn  = 1'b1;
        upd_c   = 1'b1;
      end
      OP_W'(OP_DEC): begin
        alu_res = a - ONE;
        alu_c   = (a == '0);
        upd_zn  = 1'b1;
        upd_c   = 1'b1;
      end
      OP_W'(OP_SHL): begin
        wide    = {1'b0, a} << sh;
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
        upd_zn  = 1'b1;
        upd_c   = (sh != '0);
      end
      OP_W'(OP_SHR): begin
        wide    = {a, 1'b0} >> sh;
        alu_res = wide[DATA_W:1];
        alu_c   = wide[0];
        upd_zn  = 1'b1;
        upd_c   = (sh != '0);
      end
      OP_W'(OP_MOV): begin
        alu_res = a;
      end
      OP_W'(OP_SETC): begin
        alu_c = 1'b1;
        upd_c = 1'b1;
      end
      OP_W'(OP_CLRC): begin
        alu_c = 1'b0;
        upd_c = 1'b1;
      end
      default: begin
        alu_res = '0;
      end
    endcase
  end

  // Next condition codes for a single-cycle op; untouched bits keep their value.
  always_comb begin
    ccr_next = ccr;
    if (upd_zn) begin
      ccr_next[CCR_Z] = (alu_res == '0);
      ccr_next[CCR_N] = alu_res[DATA_W-1];
    end else begin
      ccr_next[CCR_Z] = ccr[CCR_Z];
      ccr_next[CCR_N] = ccr[CCR_N];
    end
    if (upd_c) begin
      ccr_next[CCR_C] = alu_c;
    end else begin
      ccr_next[CCR_C] = ccr[CCR_C];
    end
  end

  // Issue control: accept only when the multiplier is idle; stall covers the
  // MUL accept cycle and every stepping cycle.
  always_comb begin
    is_mul     = (alu_op == OP_W'(OP_MUL));
    accept     = in_valid && !flush && !mul_busy && !mul_done;
    mul_start  = accept && is_mul;
    mul_finish = mul_last && !flush;
    stall      = mul_start || mul_busy;
  end

  mul_iter #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk          (clk),
    .rst          (rst),
    .start        (mul_start),
    .abort        (flush),
    .mcand_in     (a),
    .mplier_in    (b),
    .busy         (mul_busy),
    .done         (mul_done),
    .last         (mul_last),
    .step_product (mul_product)
  );

  // EX/MEM output registers. The multiply result is captured on the final
  // step so it is presented during the DONE cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      mem_addr  <= '0;
      ccr       <= 3'b000;
    end else begin
      if (accept) begin
        mem_addr <= branch ? op1 : op2;
      end else begin
        mem_addr <= mem_addr;
      end
      if (mul_finish) begin
        out_valid    <= 1'b1;
        result       <= mul_product[DATA_W-1:0];
        result_hi    <= mul_product[2*DATA_W-1:DATA_W];
        ccr[CCR_Z]   <= (mul_product == '0);
        ccr[CCR_N]   <= mul_product[2*DATA_W-1];
        ccr[CCR_C]   <= (mul_product[2*DATA_W-1:DATA_W] != '0);
      end else if (accept && !is_mul) begin
        out_valid <= 1'b1;
        result    <= alu_res;
        result_hi <= '0;
        ccr       <= ccr_next;
      end else begin
        out_valid <= 1'b0;
        result    <= result;
        result_hi <= result_hi;
        ccr       <= ccr;
      end
    end
  end

endmodule

// File: tb/tb_exec_stage_mc.sv
// ---------------------------------------------------------------------------
// tb_exec_stage_mc
// Directed self-checking bench for exec_stage_mc (DATA_W=16). Inputs change
// 1 time unit after a rising edge; outputs are checked at that same point.
// ---------------------------------------------------------------------------
module tb_exec_stage_mc;
  import exec_pkg::*;

  localparam int DATA_W = 16;
  localparam int OP_W   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              flush;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic [DATA_W-1:0] inport;
  logic [DATA_W-1:0] immediate;
  logic [DATA_W-1:0] shamt;
  logic [OP_W-1:0]   alu_op;
  logic [1:0]        alu_src;
  logic              in_sel;
  logic              branch;
  logic [DATA_W-1:0] ex_mem_fwd;
  logic [DATA_W-1:0] mem_wb_fwd;
  logic [1:0]        fwd1_sel;
  logic [1:0]        fwd2_sel;
  logic              stall;
  logic              out_valid;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] result_hi;
  logic [DATA_W-1:0] mem_addr;
  logic [2:0]        ccr;

  int n_checks = 0;
  int n_errors = 0;

  exec_stage_mc #(.DATA_W(DATA_W), .OP_W(OP_W), .FWD_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
    .op1(op1), .op2(op2), .inport(inport), .immediate(immediate),
    .shamt(shamt), .alu_op(alu_op), .alu_src(alu_src), .in_sel(in_sel),
    .branch(branch), .ex_mem_fwd(ex_mem_fwd), .mem_wb_fwd(mem_wb_fwd),
    .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .stall(stall),
    .out_valid(out_valid), .result(result), .result_hi(result_hi),
    .mem_addr(mem_addr), .ccr(ccr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; flush = 1'b0; op1 = '0; op2 = '0; inport = '0;
    immediate = '0; shamt = '0; alu_op = OP_NOP; alu_src = SRC_REG;
    in_sel = 1'b0; branch = 1'b0; ex_mem_fwd = '0; mem_wb_fwd = '0;
    fwd1_sel = FWD_NONE; fwd2_sel = FWD_NONE;
  endtask

  task automatic drive(input logic [4:0] op, input logic [15:0] a1, input logic [15:0] b2);
    idle_inputs();
    in_valid = 1'b1; alu_op = op; op1 = a1; op2 = b2;
  endtask

  // Single-cycle op already driven: clock it, drop in_valid, check outputs.
  task automatic issue_check(input string tag, input logic [15:0] exp_res, input logic [2:0] exp_ccr);
    step();
    in_valid = 1'b0;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_result"}, {16'd0, result}, {16'd0, exp_res});
    check({tag, "_ccr"}, {29'd0, ccr}, {29'd0, exp_ccr});
  endtask

  initial begin
    int seen;
    idle_inputs();
    rst = 1'b0;
    step(); step();
    rst = 1'b1;

    // Reset in the middle of a multiply.
    drive(OP_MUL, 16'h0003, 16'h0005);
    #1;
    check("mul_accept_stall", {31'd0, stall}, 32'd1);
    step();
    in_valid = 1'b0;
    step(); step();
    check("mul_busy_stall", {31'd0, stall}, 32'd1);
    rst = 1'b0;
    step(); step();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_result_hi", {16'd0, result_hi}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_ccr", {29'd0, ccr}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid || stall) seen++;
    end
    check("rst_quiet", seen, 32'd0);

    // ADD through the IN port: 0x7FFF + 1 = 0x8000, N set.
    drive(OP_ADD, 16'h1111, 16'h0001);
    in_sel = 1'b1; inport = 16'h7FFF; branch = 1'b1;
    issue_check("add_in", 16'h8000, 3'b010);
    check("add_in_hi", {16'd0, result_hi}, 32'd0);
    check("add_in_mem_addr", {16'd0, mem_addr}, 32'h1111);
    step();
    check("add_in_one_cycle", {31'd0, out_valid}, 32'd0);
    check("idle_hold_result", {16'd0, result}, 32'h8000);

    // SUB with b forwarded from EX/MEM: 5 - 5 = 0; mem_addr uses raw op2.
    drive(OP_SUB, 16'h0005, 16'h0009);
    fwd2_sel = FWD_EX_MEM; ex_mem_fwd = 16'h0005;
    issue_check("sub_zero", 16'h0000, 3'b001);
    check("sub_zero_mem_addr", {16'd0, mem_addr}, 32'h0009);
    // 5 - 6 borrows.
    drive(OP_SUB, 16'h0005, 16'h0006);
    issue_check("sub_borrow", 16'hFFFF, 3'b110);

    // a forwarded from MEM/WB: 0x10 + 3.
    drive(OP_ADD, 16'h0001, 16'h0003);
    fwd1_sel = FWD_MEM_WB; mem_wb_fwd = 16'h0010;
    issue_check("add_fwd1", 16'h0013, 3'b000);
    // OR with immediate; C untouched.
    drive(OP_OR, 16'h000F, 16'h1234);
    alu_src = SRC_IMM; immediate = 16'h00F0;
    issue_check("or_imm", 16'h00FF, 3'b000);

    // SETC then MOV of zero: MOV must not touch flags.
    drive(OP_SETC, 16'h5555, 16'h0000);
    issue_check("setc", 16'h0000, 3'b100);
    drive(OP_MOV, 16'h0000, 16'h0007);
    issue_check("mov", 16'h0000, 3'b100);
    // INC 0xFFFF wraps with carry.
    drive(OP_INC, 16'hFFFF, 16'h0000);
    issue_check("inc_wrap", 16'h0000, 3'b101);

    // Flush in IDLE discards the instruction.
    drive(OP_ADD, 16'h0001, 16'h0001);
    flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_valid", {31'd0, out_valid}, 32'd0);
    check("flush_idle_ccr", {29'd0, ccr}, 32'd5);

    // DEC of 0 borrows; then an unknown opcode acts as NOP.
    drive(OP_DEC, 16'h0000, 16'h0000);
    issue_check("dec_borrow", 16'hFFFF, 3'b110);
    drive(5'd31, 16'h1234, 16'h5678);
    issue_check("unknown_op", 16'h0000, 3'b110);

    // MUL 0x1234 * 0x0100 = 0x0012_3400.
    drive(OP_MUL, 16'h1234, 16'h0100);
    #1;
    check("mul_start_stall", {31'd0, stall}, 32'd1);
    step();
    in_valid = 1'b0;
    seen = 0;
    for (int i = 1; i <= 16; i++) begin
      if (!stall || out_valid) seen++;
      step();
    end
    check("mul_busy_cycles", seen, 32'd0);
    check("mul_done_stall", {31'd0, stall}, 32'd0);
    check("mul_done_valid", {31'd0, out_valid}, 32'd1);
    check("mul_result", {16'd0, result}, 32'h3400);
    check("mul_result_hi", {16'd0, result_hi}, 32'h0012);
    check("mul_ccr", {29'd0, ccr}, 32'd4);
    step();
    check("mul_valid_once", {31'd0, out_valid}, 32'd0);

    // Flush at cycle 5 of a multiply aborts it.
    drive(OP_MUL, 16'h0003, 16'h0004);
    step();
    in_valid = 1'b0;
    step(); step(); step(); step();
    check("flush_busy_pre", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy_stall", {31'd0, stall}, 32'd0);
    check("flush_busy_valid", {31'd0, out_valid}, 32'd0);
    check("flush_busy_ccr", {29'd0, ccr}, 32'd4);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid || stall) seen++;
    end
    check("flush_busy_quiet", seen, 32'd0);
    check("flush_busy_result", {16'd0, result}, 32'h3400);

    // Largest product 0xFFFF * 0xFFFF = 0xFFFE_0001; flush during DONE is too late.
    drive(OP_MUL, 16'hFFFF, 16'hFFFF);
    step();
    in_valid = 1'b0;
    seen = 0;
    while (!out_valid && seen < 40) begin
      step();
      seen++;
    end
    check("mul_max_latency", seen, 32'd16);
    flush = 1'b1;
    check("mul_max_result", {16'd0, result}, 32'h0001);
    check("mul_max_result_hi", {16'd0, result_hi}, 32'hFFFE);
    check("mul_max_ccr", {29'd0, ccr}, 32'd6);
    step();
    flush = 1'b0;
    check("mul_max_after", {31'd0, out_valid}, 32'd0);

    // Shifts: by 0 keeps C, then carry-out cases and shamt low-bit masking.
    drive(OP_SHL, 16'h8001, 16'h0000);
    alu_src = SRC_SHAMT; shamt = 16'h0000;
    issue_check("shl0", 16'h8001, 3'b110);
    drive(OP_CLRC, 16'h0000, 16'h0000);
    issue_check("clrc", 16'h0000, 3'b010);
    drive(OP_SHL, 16'h8001, 16'h0000);
    alu_src = SRC_SHAMT; shamt = 16'h0001;
    issue_check("shl1", 16'h0002, 3'b100);
    drive(OP_SHR, 16'h8018, 16'h0000);
    alu_src = SRC_SHAMT; shamt = 16'h0004;
    issue_check("shr4", 16'h0801, 3'b100);
    drive(OP_SHR, 16'h8018, 16'h0000);
    alu_src = SRC_SHAMT; shamt = 16'h0013;
    issue_check("shr3_masked", 16'h1003, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
